// File: rtl/clkgen_ctrl.sv
`default_nettype none
// ============================================================================
// clkgen_ctrl : run/stop/single-step controller with a glitch-free divider
// Rev 1.0
// ============================================================================
module clkgen_ctrl #(
   parameter int DIV_W        = 32,
   parameter int STEP_W       = 16,
   parameter int DEFAULT_HALF = 25000,
   parameter int AUTO_RUN     = 1
) (
   input  logic              clkin,
   input  logic              rst,
   input  logic              cfg_valid,
   input  logic [DIV_W-1:0]  cfg_half,
   output logic              cfg_ready,
   input  logic              cmd_valid,
   input  logic [1:0]        cmd_op,
   input  logic [STEP_W-1:0] cmd_steps,
   output logic              cmd_ready,
   output logic              clkout,
   output logic              tick,
   output logic              busy,
   output logic [1:0]        state,
   output logic [STEP_W-1:0] steps_left
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_RUN      = 2'd1,
      S_STEP     = 2'd2,
      S_STOPPING = 2'd3
   } state_t;

   localparam logic [1:0]        c_op_stop  = 2'b00;
   localparam logic [1:0]        c_op_run   = 2'b01;
   localparam logic [1:0]        c_op_step  = 2'b10;
   localparam logic [DIV_W-1:0]  c_half_one = DIV_W'(1);
   localparam logic [DIV_W-1:0]  c_half_rst = DIV_W'(DEFAULT_HALF);
   localparam logic [STEP_W-1:0] c_step_one = STEP_W'(1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [DIV_W-1:0]    r_cnt;
   logic [DIV_W-1:0]    r_cur_half;
   logic [DIV_W-1:0]    r_pending;
   logic                r_pend_v;
   logic                r_clkout;
   logic                r_tick;
   logic                r_cfg_ready;
   logic [STEP_W-1:0]   r_steps_left;
   logic [STEP_W-1:0]   w_steps_nxt;
   logic [DIV_W-1:0]    w_cfg_val;
   logic                w_cfg_hs;
   logic                w_cmd_hs;
   logic                w_toggle;
   logic                w_rise;
   logic                w_fall;

   assign cmd_ready  = (r_state != S_STOPPING);
   assign cfg_ready  = r_cfg_ready;
   assign clkout     = r_clkout;
   assign tick       = r_tick;
   assign busy       = (r_state == S_STEP) || (r_state == S_STOPPING);
   assign state      = r_state;
   assign steps_left = r_steps_left;

   assign w_cfg_hs  = cfg_valid & r_cfg_ready;
   assign w_cmd_hs  = cmd_valid & cmd_ready;
   assign w_cfg_val = (cfg_half == '0) ? c_half_one : cfg_half;

   // A low phase seen in STOPPING never toggles, so no high phase can start.
   assign w_toggle = (r_state != S_IDLE) && (r_cnt == r_cur_half - c_half_one) &&
                     !((r_state == S_STOPPING) && !r_clkout);
   assign w_rise   = w_toggle & ~r_clkout;
   assign w_fall   = w_toggle &  r_clkout;

   always_comb begin
      w_state_nxt = r_state;
      w_steps_nxt = r_steps_left;
      case (r_state)
         S_IDLE: begin
            // r_cfg_ready is low only until the first edge after reset release
            if (!r_cfg_ready && (AUTO_RUN != 0)) begin
               w_state_nxt = S_RUN;
            end else if (w_cmd_hs && (cmd_op == c_op_run)) begin
               w_state_nxt = S_RUN;
            end else if (w_cmd_hs && (cmd_op == c_op_step) && (cmd_steps != '0)) begin
               w_state_nxt = S_STEP;
               w_steps_nxt = cmd_steps;
            end
         end
         S_RUN: begin
            if (w_cmd_hs && (cmd_op == c_op_stop)) w_state_nxt = S_STOPPING;
         end
         S_STEP: begin
            if (w_cmd_hs && (cmd_op == c_op_stop)) begin
               w_state_nxt = S_STOPPING;
               w_steps_nxt = '0;
            end else if (w_rise) begin
               w_steps_nxt = r_steps_left - c_step_one;
            end else if (w_fall && (r_steps_left == '0)) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_STOPPING: begin
            if (!r_clkout || w_fall) w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clkin or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_steps_left <= '0;
         r_cfg_ready  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_steps_left <= w_steps_nxt;
         r_cfg_ready  <= 1'b1;
      end
   end

   always_ff @(posedge clkin or negedge rst) begin
      if (!rst) begin
         r_cnt    <= '0;
         r_clkout <= 1'b0;
         r_tick   <= 1'b0;
      end else begin
         r_tick <= w_rise;
         if ((w_state_nxt == S_IDLE) || (r_state == S_IDLE)) begin
            r_cnt    <= '0;
            r_clkout <= 1'b0;
         end else if (w_toggle) begin
            r_cnt    <= '0;
            r_clkout <= ~r_clkout;
         end else begin
            r_cnt <= r_cnt + c_half_one;
         end
      end
   end

   // New half-periods only take effect on a phase boundary (or while idle).
   always_ff @(posedge clkin or negedge rst) begin
      if (!rst) begin
         r_cur_half <= c_half_rst;
         r_pending  <= c_half_rst;
         r_pend_v   <= 1'b0;
      end else if ((r_state == S_IDLE) || w_toggle) begin
         if (w_cfg_hs) begin
            r_cur_half <= w_cfg_val;
            r_pend_v   <= 1'b0;
         end else if (r_pend_v) begin
            r_cur_half <= r_pending;
            r_pend_v   <= 1'b0;
         end
      end else if (w_cfg_hs) begin
         r_pending <= w_cfg_val;
         r_pend_v  <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_clkgen_ctrl.sv
`default_nettype none
// tb_clkgen_ctrl : directed and randomized checks against a phase-countdown model
module tb_clkgen_ctrl;
   localparam int DIV_W        = 8;
   localparam int STEP_W       = 8;
   localparam int DEFAULT_HALF = 4;
   localparam int AUTO_RUN     = 1;

   logic              clkin = 1'b0;
   logic              rst   = 1'b0;
   logic              cfg_valid = 1'b0;
   logic [DIV_W-1:0]  cfg_half  = '0;
   logic              cfg_ready;
   logic              cmd_valid = 1'b0;
   logic [1:0]        cmd_op    = '0;
   logic [STEP_W-1:0] cmd_steps = '0;
   logic              cmd_ready;
   logic              clkout;
   logic              tick;
   logic              busy;
   logic [1:0]        state;
   logic [STEP_W-1:0] steps_left;

   int n_total = 0;
   int n_bad   = 0;

   // model: mode 0..3, output level, cycles left in the current phase
   int m_mode, m_lvl, m_left, m_half, m_pend, m_pend_v, m_steps, m_tick, m_first;

   clkgen_ctrl #(
      .DIV_W(DIV_W), .STEP_W(STEP_W), .DEFAULT_HALF(DEFAULT_HALF), .AUTO_RUN(AUTO_RUN)
   ) u_dut (
      .clkin(clkin), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_half(cfg_half), .cfg_ready(cfg_ready),
      .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_steps(cmd_steps), .cmd_ready(cmd_ready),
      .clkout(clkout), .tick(tick), .busy(busy), .state(state), .steps_left(steps_left)
   );

   always #5 clkin = ~clkin;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_lvl = 0; m_left = 0; m_half = DEFAULT_HALF;
      m_pend = 0; m_pend_v = 0; m_steps = 0; m_tick = 0; m_first = 1;
   endtask

   task automatic model_step(input int cv, input int ch, input int mv, input int op, input int n);
      int cfg_hs, cmd_hs, newh, tog, rise, fall, nxt, was_lvl;
      cfg_hs  = (cv != 0) && (m_first == 0);
      cmd_hs  = (mv != 0) && (m_mode != 3);
      newh    = (ch == 0) ? 1 : ch;
      was_lvl = m_lvl;
      tog     = 0;
      if (m_mode != 0 && !(m_mode == 3 && m_lvl == 0)) begin
         m_left--;
         tog = (m_left == 0);
      end
      if (m_mode == 0 || tog != 0) begin
         if (cfg_hs != 0) begin m_half = newh; m_pend_v = 0; end
         else if (m_pend_v != 0) begin m_half = m_pend; m_pend_v = 0; end
      end else if (cfg_hs != 0) begin
         m_pend = newh; m_pend_v = 1;
      end
      rise = (tog != 0) && (was_lvl == 0);
      fall = (tog != 0) && (was_lvl == 1);
      if (tog != 0) begin m_lvl = 1 - m_lvl; m_left = m_half; end
      nxt = m_mode;
      case (m_mode)
         0: if (m_first != 0 && AUTO_RUN != 0) nxt = 1;
            else if (cmd_hs != 0 && op == 1) nxt = 1;
            else if (cmd_hs != 0 && op == 2 && n != 0) begin nxt = 2; m_steps = n; end
         1: if (cmd_hs != 0 && op == 0) nxt = 3;
         2: if (cmd_hs != 0 && op == 0) begin nxt = 3; m_steps = 0; end
            else if (rise != 0) m_steps--;
            else if (fall != 0 && m_steps == 0) nxt = 0;
         default: if (was_lvl == 0 || fall != 0) nxt = 0;
      endcase
      if (m_mode == 0 && nxt != 0) begin m_lvl = 0; m_left = m_half; end
      if (nxt == 0) m_lvl = 0;
      m_mode  = nxt;
      m_tick  = rise;
      m_first = 0;
   endtask

   task automatic check_all();
      check_eq("clkout", clkout, m_lvl);
      check_eq("tick", tick, m_tick);
      check_eq("state", state, m_mode);
      check_eq("busy", busy, (m_mode >= 2) ? 1 : 0);
      check_eq("steps_left", steps_left, m_steps);
      check_eq("cmd_ready", cmd_ready, (m_mode != 3) ? 1 : 0);
      check_eq("cfg_ready", cfg_ready, (m_first == 0) ? 1 : 0);
   endtask

   // called at a falling edge: drive inputs, take one rising edge, check
   task automatic cycle(input int cv, input int ch, input int mv, input int op, input int n);
      cfg_valid = (cv != 0);
      cfg_half  = DIV_W'(ch);
      cmd_valid = (mv != 0);
      cmd_op    = op[1:0];
      cmd_steps = STEP_W'(n);
      @(posedge clkin);
      model_step(cv, ch, mv, op, n);
      @(negedge clkin);
      check_all();
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) cycle(0, 0, 0, 0, 0);
   endtask

   task automatic go_idle();
      int b;
      cycle(0, 0, 1, 0, 0);
      b = 0;
      while (state != 2'd0 && b < 60) begin cycle(0, 0, 0, 0, 0); b++; end
      check_eq("go_idle", state, 0);
   endtask

   task automatic wait_tick(input string tag);
      int b;
      b = 0;
      while (tick !== 1'b1 && b < 60) begin cycle(0, 0, 0, 0, 0); b++; end
      check_eq(tag, tick, 1);
   endtask

   task automatic check_reset_values(input string tag);
      check_eq({tag, "_clkout"}, clkout, 0);
      check_eq({tag, "_tick"}, tick, 0);
      check_eq({tag, "_busy"}, busy, 0);
      check_eq({tag, "_state"}, state, 0);
      check_eq({tag, "_steps"}, steps_left, 0);
      check_eq({tag, "_cmd_ready"}, cmd_ready, 1);
      check_eq({tag, "_cfg_ready"}, cfg_ready, 0);
   endtask

   initial begin
      int cyc, ticks, cv, mv;
      model_reset();
      #23;
      check_reset_values("rst0");
      @(negedge clkin);
      rst = 1'b1;

      // auto-run out of reset, default period
      idle(30);

      // single step of 3 edges from idle
      go_idle();
      cycle(0, 0, 1, 2, 3);
      cyc = 0; ticks = 0;
      while (state != 2'd0 && cyc < 100) begin
         cycle(0, 0, 0, 0, 0);
         cyc++;
         if (tick === 1'b1) ticks++;
      end
      check_eq("step3_latency", cyc, 24);
      check_eq("step3_ticks", ticks, 3);

      // zero-length step is a no-op
      cycle(0, 0, 1, 2, 0);
      idle(6);
      check_eq("step0_state", state, 0);

      // stop a step after its second rising edge
      cycle(0, 0, 1, 2, 5);
      wait_tick("step5_tick1");
      cycle(0, 0, 0, 0, 0);
      wait_tick("step5_tick2");
      cycle(0, 0, 1, 0, 0);
      check_eq("step5_stop_steps", steps_left, 0);
      check_eq("step5_stop_ready", cmd_ready, 0);
      idle(10);

      // mid-phase reconfig, zero half, reconfig on toggle
      cycle(0, 0, 1, 1, 0);
      idle(2);
      cycle(1, 2, 0, 0, 0);
      idle(12);
      cycle(1, 0, 0, 0, 0);
      idle(6);
      cycle(1, 3, 0, 0, 0);
      idle(12);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         cv = ($urandom_range(0, 15) == 0) ? 1 : 0;
         mv = ($urandom_range(0, 11) == 0) ? 1 : 0;
         cycle(cv, int'($urandom_range(0, 5)), mv, int'($urandom_range(0, 3)),
               int'($urandom_range(0, 4)));
      end

      // async reset while high with a pending config
      go_idle();
      cycle(1, 4, 1, 1, 0);
      wait_tick("rst_tick1");
      cycle(0, 0, 0, 0, 0);
      wait_tick("rst_tick2");
      cycle(1, 2, 0, 0, 0);
      check_eq("pre_rst_clkout", clkout, 1);
      #2;
      rst = 1'b0;
      #1;
      check_reset_values("rst1");
      model_reset();
      @(negedge clkin);
      rst = 1'b1;
      idle(40);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
